// File: rtl/sha256_multiround_core.sv
// SHA-256 block compression, ROUNDS_PER_CYCLE rounds per clock; o_done 64/ROUNDS_PER_CYCLE+2 edges after start.
// Optional macro SHA224_MODE_EN adds the SHA-224 initial value selected by i_mode; no input backpressure beyond o_ready.
module sha256_multiround_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_init,
   input  logic         i_mode,
   input  logic [511:0] i_data,
   input  logic [255:0] i_vin,
   output logic [255:0] o_vout,
   output logic         o_done,
   output logic         o_ready
);
   localparam int R    = ROUNDS_PER_CYCLE;
   localparam int NCYC = 64 / R;
   localparam logic [5:0] LAST_CYC = 6'(NCYC - 1);

   if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [255:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA224_MODE_EN
   localparam logic [255:0] IV224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t       state_q;
   logic [5:0]   cnt_q;
   logic         ready_q;
   logic         done_q;
   logic [255:0] vout_q;

   logic [31:0]  h_q   [8];
   logic [31:0]  wv_q  [8];
   logic [31:0]  wv_d  [8];
   logic [31:0]  w_q   [16];
   logic [31:0]  w_d   [16];
   logic [31:0]  w_ext [16+R];
   logic [31:0]  t1;
   logic [31:0]  t2;
   logic [5:0]   kidx;
   logic [255:0] iv_sel;
   logic [255:0] chain_in;
   logic [255:0] final_sum;
   logic         accept;

`ifdef SHA224_MODE_EN
   assign iv_sel = i_mode ? IV224 : IV256;
`else
   logic unused_mode;
   assign iv_sel      = IV256;
   assign unused_mode = i_mode;
`endif

   assign chain_in = i_init ? iv_sel : i_vin;
   assign accept   = i_rst_n && i_start && (state_q == S_IDLE);

   // w_ext extends the 16-word window by the R words this cycle's rounds will consume later.
   always_comb begin
      t1   = '0;
      t2   = '0;
      kidx = '0;
      for (int k = 0; k < 16; k++) begin
         w_ext[k] = w_q[k];
      end
      for (int j = 0; j < R; j++) begin
         w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
      end
      for (int k = 0; k < 8; k++) begin
         wv_d[k] = wv_q[k];
      end
      for (int j = 0; j < R; j++) begin
         kidx = 6'(int'(cnt_q) * R + j);
         t1 = wv_d[7] + bsig1(wv_d[4]) + ((wv_d[4] & wv_d[5]) ^ (~wv_d[4] & wv_d[6]))
              + K[kidx] + w_ext[j];
         t2 = bsig0(wv_d[0]) + ((wv_d[0] & wv_d[1]) ^ (wv_d[0] & wv_d[2]) ^ (wv_d[1] & wv_d[2]));
         for (int k = 7; k > 0; k--) begin
            wv_d[k] = wv_d[k-1];
         end
         wv_d[4] = wv_d[4] + t1;
         wv_d[0] = t1 + t2;
      end
      for (int k = 0; k < 16; k++) begin
         w_d[k] = w_ext[k+R];
      end
   end

   always_comb begin
      final_sum = '0;
      for (int k = 0; k < 8; k++) begin
         final_sum[255-32*k -: 32] = h_q[k] + wv_q[k];
      end
   end

   // Datapath registers need no reset: they are always reloaded on the accepting edge.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int k = 0; k < 8; k++) begin
            h_q[k]  <= chain_in[255-32*k -: 32];
            wv_q[k] <= chain_in[255-32*k -: 32];
         end
         for (int k = 0; k < 16; k++) begin
            w_q[k] <= i_data[511-32*k -: 32];
         end
      end else if (state_q == S_ROUND) begin
         wv_q <= wv_d;
         w_q  <= w_d;
      end
   end

   // FINAL spans two cycles: cnt_q=0 writes o_vout, cnt_q=1 raises o_done and o_ready.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         vout_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_q <= S_ROUND;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            S_ROUND: begin
               if (cnt_q == LAST_CYC) begin
                  state_q <= S_FINAL;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 6'd1;
               end
            end
            S_FINAL: begin
               if (cnt_q == '0) begin
                  vout_q <= final_sum;
                  cnt_q  <= 6'd1;
               end else begin
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_vout  = vout_q;
   assign o_done  = done_q;
   assign o_ready = ready_q;

endmodule

// File: tb/tb_sha256_multiround_core.sv
// Scoreboard bench for sha256_multiround_core: one instance per legal ROUNDS_PER_CYCLE, index 0 (R=1) checked in depth.
module tb_sha256_multiround_core;
   logic         i_clk   = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic         i_init  = 1'b0;
   logic         i_mode  = 1'b0;
   logic [511:0] i_data  = '0;
   logic [255:0] i_vin   = '0;
   logic [255:0] vout [4];
   logic [3:0]   done;
   logic [3:0]   ready;

   always #5 i_clk = ~i_clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha256_multiround_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_start (i_start),
         .i_init  (i_init),
         .i_mode  (i_mode),
         .i_data  (i_data),
         .i_vin   (i_vin),
         .o_vout  (vout[g]),
         .o_done  (done[g]),
         .o_ready (ready[g])
      );
   end

   localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [255:0] ABC_256 =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] TWO_256 =
      256'hf371bc4a_311f2b00_9eef952d_d83ca80e_2b60026c_8e935592_d0f9c308_453c813e;
`ifdef SHA224_MODE_EN
   localparam logic [255:0] MODE_EXP =
      {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
   localparam logic [255:0] MODE_MSK = {{224{1'b1}}, 32'h0};
`else
   localparam logic [255:0] MODE_EXP = ABC_256;
   localparam logic [255:0] MODE_MSK = '1;
`endif

   typedef struct {
      logic [255:0] val;
      logic [255:0] msk;
      int           due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_done = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
      n_chk++;
      if (obs === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, want);
   endtask

   // Called on a falling edge; returns on the falling edge after the accepting edge.
   task automatic launch(input logic [511:0] d, input logic [255:0] v, input logic init,
                         input logic mode, input logic [255:0] val, input logic [255:0] msk);
      chk("start_ready", 256'(ready[0]), 256'(1));
      i_data  = d;
      i_vin   = v;
      i_init  = init;
      i_mode  = mode;
      i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      sb.push_back('{val, msk, cyc + 66});
      chk("busy_ready", 256'(ready[0]), 256'(0));
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done[0] && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      if (!done[0]) chk("done_timeout", 256'(done[0]), 256'(1));
   endtask

   always @(negedge i_clk) begin
      if (done[0]) begin
         n_done++;
         chk("done_ready", 256'(ready[0]), 256'(1));
         if (sb.size() == 0) begin
            chk("unexp_done", 256'(done[0]), 256'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("latency", 256'(cyc), 256'(mon_e.due));
            if (mon_e.msk != '0) chk("vout", vout[0] & mon_e.msk, mon_e.val & mon_e.msk);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [1023:0] msg2;
      int            c0;
      int            ndone [4];

      msg2 = '0;
      for (int i = 0; i < 80; i++) msg2[1023-8*i -: 8] = 8'(8'h30 + ((i % 10) + 1) % 10);
      msg2[1023-8*80 -: 8] = 8'h80;
      msg2[63:0] = 64'd640;

      // Reset with i_start held high: the start must not be taken.
      i_rst_n = 1'b0;
      i_start = 1'b1;
      i_init  = 1'b1;
      i_data  = ABC_BLK;
      repeat (3) @(negedge i_clk);
      chk("rst_ready", 256'(ready[0]), 256'(1));
      chk("rst_done", 256'(done[0]), 256'(0));
      chk("rst_vout", vout[0], 256'(0));
      i_rst_n = 1'b1;
      i_start = 1'b0;
      @(negedge i_clk);
      chk("rst_start_ign", 256'(ready[0]), 256'(1));

      // "abc" on all four round widths at once.
      launch(ABC_BLK, '0, 1'b1, 1'b0, ABC_256, '1);
      c0 = cyc;
      ndone = '{0, 0, 0, 0};
      for (int n = 0; n < 70; n++) begin
         for (int g = 1; g < 4; g++) begin
            if (done[g]) begin
               ndone[g]++;
               chk($sformatf("lat_r%0d", 1 << g), 256'(cyc - c0), 256'(64 / (1 << g) + 2));
               chk($sformatf("vout_r%0d", 1 << g), vout[g], ABC_256);
            end
         end
         @(negedge i_clk);
      end
      for (int g = 1; g < 4; g++) chk($sformatf("ndone_r%0d", 1 << g), 256'(ndone[g]), 256'(1));

      // Two-block message chained back-to-back from the o_done cycle.
      launch(msg2[1023:512], '0, 1'b1, 1'b0, '0, '0);
      wait_done(80);
      launch(msg2[511:0], vout[0], 1'b0, 1'b0, TWO_256, '1);
      wait_done(80);
      @(negedge i_clk);

      // IV selection by i_mode.
      launch(ABC_BLK, '0, 1'b1, 1'b1, MODE_EXP, MODE_MSK);
      wait_done(80);
      @(negedge i_clk);

      // Start pulse and input changes while busy are ignored.
      launch(ABC_BLK, '0, 1'b1, 1'b0, ABC_256, '1);
      repeat (20) @(negedge i_clk);
      i_start = 1'b1;
      i_data  = ~ABC_BLK;
      i_vin   = '1;
      i_init  = 1'b0;
      i_mode  = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      chk("ign_busy", 256'(ready[0]), 256'(0));
      wait_done(80);
      @(negedge i_clk);

      // One-cycle reset in the middle of the rounds aborts the block.
      launch(ABC_BLK, '0, 1'b1, 1'b0, ABC_256, '1);
      repeat (29) @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      chk("mid_rst_ready", 256'(ready[0]), 256'(1));
      chk("mid_rst_vout", vout[0], 256'(0));
      chk("mid_rst_done", 256'(done[0]), 256'(0));
      sb.delete();
      repeat (80) @(negedge i_clk);
      launch(ABC_BLK, '0, 1'b1, 1'b0, ABC_256, '1);
      wait_done(80);
      repeat (3) @(negedge i_clk);

      chk("sb_empty", 256'(sb.size()), 256'(0));
      chk("done_count", 256'(n_done), 256'(6));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sha256_multiround_core.md
SHA256_MULTIROUND_CORE -- requirements
Module: sha256_multiround_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1: compression rounds per clock; legal values 1, 2, 4, 8; any other value fails elaboration.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port i_start  input  1  request one 512-bit block compression; honoured only while o_ready=1.
REQ-005 SHALL have port i_init  input  1  sampled with i_start; 1 = use internal IV, 0 = use i_vin as chaining value.
REQ-006 SHALL have port i_mode  input  1  sampled with i_start; 0 = SHA-256 IV, 1 = SHA-224 IV (see Configuration).
REQ-007 SHALL have port i_data  input  512  padded message block, word W0 at bits [511:480], big-endian.
REQ-008 SHALL have port i_vin  input  256  chaining value H0..H7, H0 at bits [255:224].
REQ-009 SHALL have port o_vout  output  256  updated chaining value, same packing as i_vin.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse, o_vout valid.
REQ-011 SHALL have port o_ready  output  1  core idle, i_start accepted.

Function
REQ-012 SHALL implement FSM IDLE -> ROUND -> FINAL -> IDLE.
REQ-013 IDLE: o_ready=1; i_start=1 latches i_data, i_vin/IV, working vars a..h, round counter=0; next state ROUND.
REQ-014 ROUND: executes ROUNDS_PER_CYCLE rounds per cycle for exactly 64/ROUNDS_PER_CYCLE cycles, then FINAL.
REQ-015 Message schedule SHALL use a 16-word sliding window, producing ROUNDS_PER_CYCLE new W words per cycle; K constants per FIPS 180-4.
REQ-016 FINAL: o_vout <= latched chaining value + a..h, word-wise mod 2^32; o_done=1 in the following cycle for exactly one cycle.
REQ-017 Latency: o_done high exactly 64/ROUNDS_PER_CYCLE+2 rising edges after the edge sampling i_start (66 at default).
REQ-018 o_ready SHALL be 0 from the edge accepting i_start until the edge asserting o_done; o_ready=1 in the o_done cycle.
REQ-019 i_start during o_done cycle SHALL be accepted (back-to-back), allowing i_vin=o_vout chaining with zero idle cycles.
REQ-020 i_start while o_ready=0 SHALL be ignored with no effect on the operation in progress.
REQ-021 i_data, i_vin, i_init, i_mode SHALL be sampled only on accepting edge; later changes have no effect.
REQ-022 o_vout SHALL hold its value until the next FINAL update.

Reset
REQ-023 i_rst_n=0 at a rising edge SHALL force IDLE, o_done=0, o_ready=1, o_vout=0, round counter=0, aborting any operation without output.
REQ-024 i_start asserted in a reset cycle SHALL be ignored.

Configuration
REQ-025 Macro SHA224_MODE_EN defined: i_mode=1 with i_init=1 selects SHA-224 IV c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4; o_vout stays 256 bits, digest = o_vout[255:32].
REQ-026 SHA224_MODE_EN undefined: i_mode ignored, i_init=1 always selects SHA-256 IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; no SHA-224 IV logic synthesised.

Verification
REQ-027 i_init=1, i_mode=0, block "abc" padded (61626380, zeros, length 0x18), each ROUNDS_PER_CYCLE in {1,2,4,8} -> o_vout=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad at latency per REQ-017.
REQ-028 80-char "1234567890"x8, two blocks, second started in first's o_done cycle with i_init=0, i_vin=o_vout -> final o_vout=f371bc4a311f2b009eef952dd83ca80e2b60026c8e935592d0f9c308453c813e, no idle cycle between blocks.
REQ-029 SHA224_MODE_EN defined, i_mode=1, i_init=1, "abc" block -> o_vout[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7; undefined -> SHA-256 "abc" result.
REQ-030 i_start pulsed and i_data/i_vin changed at mid-ROUND -> ignored, o_done once, "abc" result unchanged.
REQ-031 i_rst_n=0 for one cycle at round 30 -> o_ready=1, o_vout=0, no o_done; fresh "abc" start afterwards -> correct digest.
